// File: rtl/clkchk_mph.sv
`default_nettype none
// ============================================================================
// Module   : clkchk_mph
// Purpose  : Checks a one-hot rotating multi-phase clock bus for one-hot
//            validity and rotation, with lock tracking and error counting.
// Revision : 1.0  initial release
// ============================================================================
module clkchk_mph #(
    parameter int Np       = 4,
    parameter int LOCK_N   = 8,
    parameter int UNLOCK_N = 2,
    parameter int CW       = 8,
    localparam int IW      = (Np > 2) ? $clog2(Np) : 1
) (
    input  logic          cki,
    input  logic          rst,
    input  logic [Np-1:0] phi,
    input  logic          clr_cnt,
    output logic [IW-1:0] idx,
    output logic          vld,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_cnt
);

    localparam int MAXN = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
    localparam int CNTW = $clog2(MAXN) + 1;
    localparam logic [CNTW-1:0] LOCK_LAST   = CNTW'(LOCK_N - 1);
    localparam logic [CNTW-1:0] UNLOCK_LAST = CNTW'(UNLOCK_N - 1);

    generate
        if (Np < 2) begin : g_bad_np
            $error("clkchk_mph: Np must be >= 2");
        end
        if (LOCK_N < 1 || UNLOCK_N < 1) begin : g_bad_thresh
            $error("clkchk_mph: LOCK_N and UNLOCK_N must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ACQ  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [CNTW-1:0] gcnt, gcnt_n;
    logic [CNTW-1:0] mcnt, mcnt_n;
    logic [Np-1:0]   s1;
    logic            h;
    logic            onehot, good, bad, err_n;
    logic [IW-1:0]   idx_n;
    logic [CW-1:0]   cnt_n;

    // Expected phase moves one bit up, MSB wrapping to bit 0.
    assign onehot = $onehot(phi);
    assign good   = onehot && h && (phi == {s1[Np-2:0], s1[Np-1]});
    assign bad    = h && !good;

    always_comb begin
        idx_n = idx;
        if (onehot) begin
            for (int i = 0; i < Np; i++) begin
                if (phi[i]) idx_n = IW'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        gcnt_n  = gcnt;
        mcnt_n  = mcnt;
        err_n   = 1'b0;
        case (state)
            ACQ: begin
                if (good) begin
                    if (gcnt == LOCK_LAST) begin
                        state_n = LOCK;
                        gcnt_n  = '0;
                    end else begin
                        gcnt_n = gcnt + CNTW'(1);
                    end
                end else if (bad) begin
                    gcnt_n = '0;
                end
            end
            LOCK: begin
                if (good) begin
                    mcnt_n = '0;
                end else if (bad) begin
                    err_n = 1'b1;
                    if (mcnt == UNLOCK_LAST) begin
                        state_n = ACQ;
                        mcnt_n  = '0;
                        gcnt_n  = '0;
                    end else begin
                        mcnt_n = mcnt + CNTW'(1);
                    end
                end
            end
            default: begin
                state_n = ACQ;
                gcnt_n  = '0;
                mcnt_n  = '0;
            end
        endcase
    end

    // A clear coinciding with a new error leaves that error counted.
    always_comb begin
        cnt_n = err_cnt;
        if (clr_cnt) begin
            cnt_n = err_n ? CW'(1) : '0;
        end else if (err_n && (err_cnt != {CW{1'b1}})) begin
            cnt_n = err_cnt + CW'(1);
        end
    end

    always_ff @(posedge cki) begin
        if (rst) begin
            state   <= ACQ;
            gcnt    <= '0;
            mcnt    <= '0;
            s1      <= '0;
            h       <= 1'b0;
            idx     <= '0;
            vld     <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            gcnt    <= gcnt_n;
            mcnt    <= mcnt_n;
            s1      <= phi;
            h       <= 1'b1;
            idx     <= idx_n;
            vld     <= onehot;
            locked  <= (state_n == LOCK);
            err     <= err_n;
            err_cnt <= cnt_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clkchk_mph.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkchk_mph
// Purpose  : Directed self-checking bench for clkchk_mph (three configurations).
// Revision : 1.0  initial release
// ============================================================================
module tb_clkchk_mph;

    logic cki = 1'b0;
    always #5 cki = ~cki;

    // a: Np=4 LOCK_N=4 UNLOCK_N=2 CW=8
    logic       rst_a, clr_a;
    logic [3:0] phi_a;
    logic [1:0] idx_a;
    logic       vld_a, locked_a, err_a;
    logic [7:0] cnt_a;

    // b: Np=4 LOCK_N=1 UNLOCK_N=1 CW=2
    logic       rst_b, clr_b;
    logic [3:0] phi_b;
    logic [1:0] idx_b;
    logic       vld_b, locked_b, err_b;
    logic [1:0] cnt_b;

    // c: Np=2 LOCK_N=1 UNLOCK_N=1
    logic       rst_c, clr_c;
    logic [1:0] phi_c;
    logic [0:0] idx_c;
    logic       vld_c, locked_c, err_c;
    logic [7:0] cnt_c;

    clkchk_mph #(.Np(4), .LOCK_N(4), .UNLOCK_N(2), .CW(8)) dut_a (
        .cki(cki), .rst(rst_a), .phi(phi_a), .clr_cnt(clr_a),
        .idx(idx_a), .vld(vld_a), .locked(locked_a), .err(err_a), .err_cnt(cnt_a)
    );

    clkchk_mph #(.Np(4), .LOCK_N(1), .UNLOCK_N(1), .CW(2)) dut_b (
        .cki(cki), .rst(rst_b), .phi(phi_b), .clr_cnt(clr_b),
        .idx(idx_b), .vld(vld_b), .locked(locked_b), .err(err_b), .err_cnt(cnt_b)
    );

    clkchk_mph #(.Np(2), .LOCK_N(1), .UNLOCK_N(1), .CW(8)) dut_c (
        .cki(cki), .rst(rst_c), .phi(phi_c), .clr_cnt(clr_c),
        .idx(idx_c), .vld(vld_c), .locked(locked_c), .err(err_c), .err_cnt(cnt_c)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge cki);
        #1;
    endtask

    // Drive one sample into dut_a, then check idx/vld/locked/err.
    task automatic step_a(input string tag, input logic [3:0] p,
                          input logic [1:0] e_idx, input logic e_vld,
                          input logic e_lock, input logic e_err);
        phi_a = p;
        tick();
        check({tag, ".idx"},    32'(idx_a),    32'(e_idx));
        check({tag, ".vld"},    32'(vld_a),    32'(e_vld));
        check({tag, ".locked"}, 32'(locked_a), 32'(e_lock));
        check({tag, ".err"},    32'(err_a),    32'(e_err));
    endtask

    initial begin
        rst_a = 1'b1; clr_a = 1'b0; phi_a = 4'b0000;
        rst_b = 1'b1; clr_b = 1'b0; phi_b = 4'b0000;
        rst_c = 1'b1; clr_c = 1'b0; phi_c = 2'b00;
        tick(); tick();

        check("rst.idx",    32'(idx_a),    32'd0);
        check("rst.vld",    32'(vld_a),    32'd0);
        check("rst.locked", 32'(locked_a), 32'd0);
        check("rst.err",    32'(err_a),    32'd0);
        check("rst.cnt",    32'(cnt_a),    32'd0);

        // Acquire lock on the fifth sample edge
        rst_a = 1'b0;
        step_a("t1.s1", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        step_a("t1.s2", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        step_a("t1.s3", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        step_a("t1.s4", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        step_a("t1.s5", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        // Non-one-hot glitch, then the transition out of it
        step_a("t2.bad", 4'b0011, 2'd0, 1'b0, 1'b1, 1'b1);
        check("t2.cnt1", 32'(cnt_a), 32'd1);
        step_a("t2.rec", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        check("t2.cnt2", 32'(cnt_a), 32'd2);

        step_a("t3.r1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        step_a("t3.r2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        step_a("t3.r3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        step_a("t3.r4", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        // Reverse rotation
        step_a("t3.v1", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
        step_a("t3.v2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        step_a("t3.v3", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        check("t3.cnt", 32'(cnt_a), 32'd4);

        // Relock, then reset mid-lock
        step_a("t5.r1", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        step_a("t5.r2", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        step_a("t5.r3", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        step_a("t5.r4", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        rst_a = 1'b1;
        step_a("t5.rst", 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t5.rst.cnt", 32'(cnt_a), 32'd0);
        rst_a = 1'b0;
        step_a("t5.h0", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        step_a("t5.g1", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        step_a("t5.g2", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        step_a("t5.g3", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        step_a("t5.g4", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);

        // Saturating counter with CW=2
        rst_b = 1'b0;
        phi_b = 4'b0001; tick();
        phi_b = 4'b0010; tick();
        check("t4.lock", 32'(locked_b), 32'd1);
        phi_b = 4'b0000; tick();
        check("t4.err",  32'(err_b), 32'd1);
        check("t4.vld",  32'(vld_b), 32'd0);
        check("t4.idx",  32'(idx_b), 32'd1);
        check("t4.cnt1", 32'(cnt_b), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            phi_b = 4'b0001; tick();
            phi_b = 4'b0010; tick();
            phi_b = 4'b0000; tick();
            check($sformatf("t4.cnt%0d", k), 32'(cnt_b), (k > 3) ? 32'd3 : 32'(k));
        end
        clr_b = 1'b1; phi_b = 4'b0001; tick();
        check("t4.clr", 32'(cnt_b), 32'd0);
        clr_b = 1'b0; phi_b = 4'b0010; tick();
        check("t4.relock", 32'(locked_b), 32'd1);
        clr_b = 1'b1; phi_b = 4'b0000; tick();
        check("t4.clr_err.err", 32'(err_b), 32'd1);
        check("t4.clr_err.cnt", 32'(cnt_b), 32'd1);
        clr_b = 1'b0;

        // Two-phase bus
        rst_c = 1'b0;
        phi_c = 2'b01; tick();
        check("t6.e1.idx",    32'(idx_c),    32'd0);
        check("t6.e1.locked", 32'(locked_c), 32'd0);
        phi_c = 2'b10; tick();
        check("t6.e2.idx",    32'(idx_c),    32'd1);
        check("t6.e2.locked", 32'(locked_c), 32'd1);
        check("t6.e2.err",    32'(err_c),    32'd0);
        phi_c = 2'b10; tick();
        check("t6.e3.err",    32'(err_c),    32'd1);
        check("t6.e3.locked", 32'(locked_c), 32'd0);
        check("t6.e3.cnt",    32'(cnt_c),    32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
